// File: rtl/rib_bus.sv
// rib_bus: shared, registered multi-master / multi-slave system bus.
// Arbitrates requesters and decodes the upper address bits to a slave select.
// Every transfer ends with a one-cycle response pulse to its owner. A hung
// slave is turned into an error response by a timeout counter.
module rib_bus #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 4,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_hold,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic [NUM_SLAVES-1:0]         s_sel,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]         s_ready
);

  // Master index width (at least one bit so a single master still works).
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Counter only ever reaches TIMEOUT-1, so this width never wraps.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [MW-1:0]           owner_reg, owner_next;
  logic [MW-1:0]           ptr_reg, ptr_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [NUM_SLAVES-1:0]   sel_next;
  logic                    we_next;
  logic [ADDR_W-1:0]       addr_next;
  logic [DATA_W-1:0]       wdata_next;
  logic [NUM_MASTERS-1:0]  rvalid_next;
  logic [DATA_W-1:0]       rdata_next;
  logic                    err_next;

  // Unpacked views of the packed master and slave buses.
  logic [ADDR_W-1:0]       addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]       wdata_arr [NUM_MASTERS];
  logic [DATA_W-1:0]       rdata_arr [NUM_SLAVES];
  logic [NUM_MASTERS-1:0]  above_ptr;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
      // Masters strictly after the last winner get first look in round-robin.
      assign above_ptr[gi] = (MW'(gi) > ptr_reg);
    end
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign rdata_arr[gi] = s_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [MW-1:0]           win;
  logic [NUM_MASTERS-1:0]  req_hi;
  logic [ADDR_W-1:0]       win_addr;
  logic [SEL_W-1:0]        sel_bits;
  logic                    dec_ok;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic [DATA_W-1:0]       rdata_sel;
  logic                    ready_sel;

  // Winner select: lowest requester, or lowest requester after the pointer
  // (wrapping to the lowest overall) in round-robin mode.
  always_comb begin
    req_hi = m_req & above_ptr;
    win    = '0;
    if (ARB_MODE == 1 && |req_hi) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (req_hi[i]) win = MW'(i);
    end else begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (m_req[i]) win = MW'(i);
    end
  end

  // Address decode of the winning master and the selected slave's response.
  always_comb begin
    win_addr   = addr_arr[win];
    sel_bits   = win_addr[ADDR_W-1 -: SEL_W];
    dec_ok     = (int'(sel_bits) < NUM_SLAVES);
    dec_onehot = NUM_SLAVES'(1) << sel_bits;
    ready_sel  = |(s_ready & s_sel);
    rdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (s_sel[i]) rdata_sel = rdata_sel | rdata_arr[i];
  end

  // Bus FSM next-state and combinational grant.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    sel_next   = s_sel;
    we_next    = s_we;
    addr_next  = s_addr;
    wdata_next = s_wdata;
    rdata_next = m_rdata;
    err_next   = m_err;
    m_gnt      = '0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (|m_req) begin
          m_gnt      = NUM_MASTERS'(1) << win;
          owner_next = win;
          we_next    = m_we[win];
          addr_next  = win_addr;
          wdata_next = wdata_arr[win];
          if (ARB_MODE == 1) ptr_next = win;
          if (dec_ok) begin
            sel_next   = dec_onehot;
            state_next = BUSY;
          end else begin
            sel_next   = '0;
            rdata_next = '0;
            err_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      BUSY: begin
        if (ready_sel) begin
          // Ready wins even on the last allowed cycle.
          rdata_next = rdata_sel;
          err_next   = 1'b0;
          sel_next   = '0;
          state_next = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rdata_next = '0;
          err_next   = 1'b1;
          sel_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    rvalid_next = (state_next == RESP) ? (NUM_MASTERS'(1) << owner_next) : '0;
  end

  assign m_hold = m_req & ~m_gnt;

  // State and registered bus outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= MW'(NUM_MASTERS - 1);
      cnt_reg   <= '0;
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      m_rvalid  <= '0;
      m_rdata   <= '0;
      m_err     <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      s_sel     <= sel_next;
      s_we      <= we_next;
      s_addr    <= addr_next;
      s_wdata   <= wdata_next;
      m_rvalid  <= rvalid_next;
      m_rdata   <= rdata_next;
      m_err     <= err_next;
    end
  end

endmodule

// File: tb/tb_rib_bus.sv
// Directed bench for rib_bus: one fixed-priority and one round-robin
// instance share the same stimulus; both use TIMEOUT = 8.
module tb_rib_bus;

  logic         clk;
  logic         rst_n;
  logic [1:0]   m_req;
  logic [1:0]   m_we;
  logic [63:0]  m_addr;
  logic [63:0]  m_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  logic [1:0]  d0_gnt, d0_hold, d0_rvalid, d1_gnt, d1_hold, d1_rvalid;
  logic [31:0] d0_rdata, d1_rdata, d0_saddr, d1_saddr, d0_swdata, d1_swdata;
  logic        d0_err, d1_err, d0_swe, d1_swe;
  logic [3:0]  d0_ssel, d1_ssel;

  int checks = 0;
  int errors = 0;

  rib_bus #(.NUM_MASTERS(2), .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SEL_W(4),
            .ARB_MODE(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(d0_gnt), .m_hold(d0_hold), .m_rvalid(d0_rvalid),
    .m_rdata(d0_rdata), .m_err(d0_err), .s_sel(d0_ssel), .s_we(d0_swe),
    .s_addr(d0_saddr), .s_wdata(d0_swdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  rib_bus #(.NUM_MASTERS(2), .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SEL_W(4),
            .ARB_MODE(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(d1_gnt), .m_hold(d1_hold), .m_rvalid(d1_rvalid),
    .m_rdata(d1_rdata), .m_err(d1_err), .s_sel(d1_ssel), .s_we(d1_swe),
    .s_addr(d1_saddr), .s_wdata(d1_swdata), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_rdata = '0;
    s_ready = '0;
    #3;
    // Reset values
    check("rst_rvalid", 64'(d0_rvalid), 64'h0);
    check("rst_rdata",  64'(d0_rdata),  64'h0);
    check("rst_err",    64'(d0_err),    64'h0);
    check("rst_ssel",   64'(d0_ssel),   64'h0);
    check("rst_swe",    64'(d0_swe),    64'h0);
    check("rst_saddr",  64'(d0_saddr),  64'h0);
    check("rst_swdata", 64'(d0_swdata), 64'h0);
    check("rst_gnt",    64'(d0_gnt),    64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single read, M0 -> slave 1, zero wait states
    m_addr[31:0]     = 32'h1000_0004;
    m_req            = 2'b01;
    s_rdata[63:32]   = 32'hDEAD_BEEF;
    s_ready          = 4'b0010;
    #1;
    check("rd_gnt0",  64'(d0_gnt),  64'h1);
    check("rd_gnt1",  64'(d1_gnt),  64'h1);
    check("rd_hold",  64'(d0_hold), 64'h0);
    step();
    m_req = 2'b00;
    check("rd_ssel",   64'(d0_ssel),   64'h2);
    check("rd_saddr",  64'(d0_saddr),  64'h1000_0004);
    check("rd_swe",    64'(d0_swe),    64'h0);
    check("rd_rv_c1",  64'(d0_rvalid), 64'h0);
    step();
    check("rd_rvalid", 64'(d0_rvalid), 64'h1);
    check("rd_rdata",  64'(d0_rdata),  64'hDEAD_BEEF);
    check("rd_err",    64'(d0_err),    64'h0);
    check("rd_ssel_c2", 64'(d0_ssel),  64'h0);
    step();
    check("rd_rv_c3",  64'(d0_rvalid), 64'h0);

    // Write, M1 -> slave 2, three wait states
    s_ready          = 4'b0000;
    m_req            = 2'b10;
    m_we             = 2'b10;
    m_addr[63:32]    = 32'h2000_0000;
    m_wdata[63:32]   = 32'h0000_0055;
    s_rdata[95:64]   = 32'h0000_A5A5;
    #1;
    check("wr_gnt0", 64'(d0_gnt), 64'h2);
    check("wr_gnt1", 64'(d1_gnt), 64'h2);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) m_req = 2'b00;
      check("wr_swe",    64'(d0_swe),    64'h1);
      check("wr_swdata", 64'(d0_swdata), 64'h55);
      check("wr_ssel",   64'(d0_ssel),   64'h4);
      check("wr_rv_wait", 64'(d0_rvalid), 64'h0);
      if (k == 4) s_ready = 4'b0100;
    end
    step();
    check("wr_rvalid", 64'(d0_rvalid), 64'h2);
    check("wr_rdata",  64'(d0_rdata),  64'hA5A5);
    check("wr_err",    64'(d0_err),    64'h0);
    s_ready = 4'b0000;
    m_we    = 2'b00;
    step();

    // Contention: both masters request continuously
    s_ready          = 4'b1111;
    s_rdata[63:32]   = 32'h1111_1111;
    s_rdata[95:64]   = 32'h2222_2222;
    m_addr[31:0]     = 32'h1000_0000;
    m_addr[63:32]    = 32'h2000_0000;
    m_req            = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("fp_gnt",  64'(d0_gnt),  64'h1);
      check("fp_hold", 64'(d0_hold), 64'h2);
      check("rr_gnt",  64'(d1_gnt),  (t % 2 == 0) ? 64'h1 : 64'h2);
      step();
      check("fp_hold_busy", 64'(d0_hold), 64'h3);
      check("rr_ssel", 64'(d1_ssel), (t % 2 == 0) ? 64'h2 : 64'h4);
      step();
      check("fp_rvalid", 64'(d0_rvalid), 64'h1);
      check("fp_rdata",  64'(d0_rdata),  64'h1111_1111);
      check("rr_rvalid", 64'(d1_rvalid), (t % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_rdata",  64'(d1_rdata),  (t % 2 == 0) ? 64'h1111_1111 : 64'h2222_2222);
      step();
    end
    m_req = 2'b00;
    #1;
    check("ct_gnt_idle", 64'(d0_gnt), 64'h0);

    // Decode error: slave index 15 with four slaves
    s_ready      = 4'b0000;
    m_addr[31:0] = 32'hF000_0000;
    m_req        = 2'b01;
    #1;
    check("de_gnt", 64'(d0_gnt), 64'h1);
    step();
    m_req = 2'b00;
    check("de_rvalid", 64'(d0_rvalid), 64'h1);
    check("de_err",    64'(d0_err),    64'h1);
    check("de_rdata",  64'(d0_rdata),  64'h0);
    check("de_ssel",   64'(d0_ssel),   64'h0);
    step();
    check("de_rv_after", 64'(d0_rvalid), 64'h0);

    // Timeout: slave 3 never ready
    m_addr[31:0] = 32'h3000_0000;
    m_req        = 2'b01;
    #1;
    check("to_gnt", 64'(d0_gnt), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) m_req = 2'b00;
      check("to_ssel",    64'(d0_ssel),   64'h8);
      check("to_rv_wait", 64'(d0_rvalid), 64'h0);
    end
    step();
    check("to_rvalid", 64'(d0_rvalid), 64'h1);
    check("to_err",    64'(d0_err),    64'h1);
    check("to_rdata",  64'(d0_rdata),  64'h0);
    check("to_ssel_end", 64'(d0_ssel), 64'h0);
    step();
    // New request after timeout completes normally
    m_addr[63:32]  = 32'h1000_0008;
    s_rdata[63:32] = 32'hCAFE_F00D;
    s_ready        = 4'b0010;
    m_req          = 2'b10;
    #1;
    check("to_next_gnt0", 64'(d0_gnt), 64'h2);
    check("to_next_gnt1", 64'(d1_gnt), 64'h2);
    step();
    m_req = 2'b00;
    step();
    check("to_next_rvalid", 64'(d0_rvalid), 64'h2);
    check("to_next_rdata",  64'(d0_rdata),  64'hCAFE_F00D);
    check("to_next_err",    64'(d0_err),    64'h0);
    step();

    // Ready in the final allowed cycle beats the timeout
    s_ready          = 4'b0000;
    m_addr[31:0]     = 32'h3000_0000;
    s_rdata[127:96]  = 32'h0BAD_C0DE;
    m_req            = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) m_req = 2'b00;
      if (k == 8) s_ready = 4'b1000;
    end
    step();
    check("last_rvalid", 64'(d0_rvalid), 64'h1);
    check("last_err",    64'(d0_err),    64'h0);
    check("last_rdata",  64'(d0_rdata),  64'h0BAD_C0DE);
    s_ready = 4'b0000;
    step();

    // Reset pulsed while BUSY
    m_addr[31:0]   = 32'h1000_0004;
    m_we           = 2'b01;
    m_wdata[31:0]  = 32'h0000_0077;
    m_req          = 2'b01;
    step();
    m_req = 2'b00;
    check("ar_ssel_busy", 64'(d0_ssel), 64'h2);
    check("ar_swe_busy",  64'(d0_swe),  64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_ssel",   64'(d0_ssel),   64'h0);
    check("ar_swe",    64'(d0_swe),    64'h0);
    check("ar_saddr",  64'(d0_saddr),  64'h0);
    check("ar_swdata", 64'(d0_swdata), 64'h0);
    check("ar_rvalid", 64'(d0_rvalid), 64'h0);
    check("ar_rdata",  64'(d0_rdata),  64'h0);
    step();
    step();
    rst_n   = 1'b1;
    s_ready = 4'b0010;
    m_we    = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ar_no_rvalid", 64'(d0_rvalid | d1_rvalid), 64'h0);
    end
    s_rdata[63:32] = 32'hDEAD_BEEF;
    m_req          = 2'b01;
    #1;
    check("ar_next_gnt0", 64'(d0_gnt), 64'h1);
    check("ar_next_gnt1", 64'(d1_gnt), 64'h1);
    step();
    m_req = 2'b00;
    step();
    check("ar_next_rvalid", 64'(d0_rvalid), 64'h1);
    check("ar_next_rdata",  64'(d0_rdata),  64'hDEAD_BEEF);
    check("ar_next_err",    64'(d0_err),    64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rib_bus.md
# rib_bus

Parametrised multi-master, multi-slave system bus for the RISC-V core. It replaces the core's fixed point-to-point ROM/RAM wiring with one shared, registered bus. The bus arbitrates among NUM_MASTERS requesters (core fetch, core load/store, debug/DMA), decodes the upper address bits to one of NUM_SLAVES targets, and completes every transfer with a response pulse. Slaves may insert wait states. A timeout converts a hung slave into an error response.

## Interface
- NUM_MASTERS, 2: number of requesters, 1..8.
- NUM_SLAVES, 4: number of targets, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SEL_W, 4: address MSBs used for slave decode; addr[ADDR_W-1 -: SEL_W] is the slave index.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 255: maximum BUSY cycles without s_ready before error completion; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held high until granted.
- m_we  in  NUM_MASTERS  1 = write, 0 = read.
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data.
- m_gnt  out  NUM_MASTERS  one-hot, combinational; high in the cycle a request is captured.
- m_hold  out  NUM_MASTERS  m_req & ~m_gnt; stall for the core pipeline.
- m_rvalid  out  NUM_MASTERS  one-cycle registered completion pulse to the owning master.
- m_rdata  out  DATA_W  registered read data; valid while any m_rvalid is high.
- m_err  out  1  registered; high with m_rvalid on decode error or timeout.
- s_sel  out  NUM_SLAVES  registered one-hot slave select.
- s_we  out  1  registered write enable; qualified by s_sel.
- s_addr  out  ADDR_W  registered address, all bits forwarded.
- s_wdata  out  DATA_W  registered write data.
- s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data.
- s_ready  in  NUM_SLAVES  per-slave completion; sampled only for the selected slave.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - When |m_req is high, choose winner w per ARB_MODE and assert m_gnt[w] combinationally.
  - At the clock edge, register owner = w, s_addr, s_we and s_wdata from master w. Compute decode index = m_addr[w] MSBs.
  - If index < NUM_SLAVES: s_sel = 1<<index, go to BUSY.
  - Otherwise: s_sel = 0, go to RESP with err = 1 and rdata = 0.
- **BUSY**
  - The timeout counter starts at 0 and increments each cycle.
  - When s_ready[index] is high: capture s_rdata[index] (captured for writes too), err = 0, go to RESP.
  - When the counter reaches TIMEOUT-1 without ready: rdata = 0, err = 1, go to RESP.
  - Ready in that same final cycle takes precedence over timeout.
  - s_sel clears on exit from BUSY.
- **RESP**
  - m_rvalid[owner] = 1 and m_rdata/m_err are valid for exactly this cycle. Return to IDLE.
  - m_gnt is 0 in BUSY and RESP.
- Round-robin:
  - The pointer holds the last winner.
  - The search starts at pointer+1 modulo NUM_MASTERS.
  - The pointer updates only on a grant.
- Fixed-priority mode ignores the pointer.
- m_hold is asserted for every requesting master not granted, including all requesters during BUSY and RESP.

## Timing
- Reset values:
  - State = IDLE, pointer = NUM_MASTERS-1 (so master 0 wins first).
  - m_rvalid = 0, m_rdata = 0, m_err = 0.
  - s_sel = 0, s_we = 0, s_addr = 0, s_wdata = 0.
  - Counter = 0.
- Reset asserted mid-transfer aborts it immediately. No m_rvalid is produced for the aborted transfer.
- Latency from the grant cycle G:
  - Slave signals are valid in G+1.
  - With ready at G+1+k, m_rvalid is high in G+2+k.
  - Zero-wait-state slave: rvalid at G+2.
  - Decode error: rvalid at G+1.
  - Timeout: rvalid at G+1+TIMEOUT.
- Back-to-back throughput: one transfer per 3 cycles minimum. The next grant can occur in the cycle after RESP.
- A request arriving during BUSY or RESP waits. Requests are not lost as long as the master holds m_req.
- Counter width is clog2(TIMEOUT+1). The counter never wraps because the FSM exits at TIMEOUT-1.

## Test plan
- Single read, M0 → addr 0x1000_0004, slave 1 ready immediately, s_rdata = 0xDEADBEEF:
  - m_gnt = 01 at cycle 0, s_sel = 0010 at cycle 1.
  - m_rvalid[0] with m_rdata = 0xDEADBEEF, m_err = 0 at cycle 2.
- Write with wait states, M1 → addr 0x2000_0000, wdata 0x55, ready after 3 waits:
  - s_we = 1, s_wdata = 0x55 held through cycles 1..4.
  - m_rvalid[1] at cycle 5.
- Contention: M0 and M1 request together, continuously.
  - ARB_MODE = 0: M0 is granted every transfer and m_hold[1] stays high.
  - ARB_MODE = 1: grants alternate 0, 1, 0, 1.
- Decode error, NUM_SLAVES = 4, addr 0xF000_0000:
  - s_sel stays 0.
  - m_rvalid with m_err = 1 and m_rdata = 0 one cycle after the grant.
- Timeout, TIMEOUT = 8, slave never ready:
  - Error response at grant+9, then a new request is granted normally.
- rst_n pulsed low while in BUSY:
  - All outputs return to reset values asynchronously and no rvalid follows.
  - The next request completes normally.
